// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Sends a DBIT-wide word LSB-first as start bit, data bits, optional parity
// and STOP_BITS stop bits. Each serial bit lasts OVERSAMPLE baud_tick pulses.
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit after the data
// bits (even parity, or odd when PARITY_ODD=1). Without it there is no parity
// state or logic and PARITY_ODD is ignored.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high, waiting for tx_start
// START  | driving the start bit (0)
// DATA   | driving shift-register LSB, n counts data bits sent
// PARITY | driving the parity bit computed at accept (macro builds only)
// STOP   | driving stop bit(s) high; sb counts stop bits when STOP_BITS=2

module uart_tx_frame #(
   parameter int DBIT       = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            baud_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] d_in,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done
);

   localparam int S_W = $clog2(OVERSAMPLE);
   localparam int N_W = $clog2(DBIT);
   localparam logic [S_W-1:0] S_MAX = S_W'(OVERSAMPLE - 1);
   localparam logic [N_W-1:0] N_MAX = N_W'(DBIT - 1);

   // Reject illegal parameter combinations at elaboration.
   if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
      $error("uart_tx_frame: DBIT must be 5..9");
   end
   if (OVERSAMPLE < 2) begin : g_bad_os
      $error("uart_tx_frame: OVERSAMPLE must be >= 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
      $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   state_t          state_q, state_d;
   logic [S_W-1:0]  s_q, s_d;
   logic [N_W-1:0]  n_q, n_d;
   logic [DBIT-1:0] shreg_q, shreg_d;
   logic            sb_q, sb_d;
   logic            tx_d, busy_d, done_d;
   logic            bit_end;
`ifdef UART_TX_PARITY_EN
   logic            par_q, par_d;
`endif

   // State and registered outputs; reset aborts any frame and idles the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         shreg_q <= '0;
         sb_q    <= 1'b0;
         tx      <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         shreg_q <= shreg_d;
         sb_q    <= sb_d;
         tx      <= tx_d;
         tx_busy <= busy_d;
         tx_done <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next-state logic; tx is derived from the state being entered so the
   // registered line changes on the same edge as the state.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shreg_d = shreg_q;
      sb_d    = sb_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      bit_end = baud_tick && (s_q == S_MAX);

      if (baud_tick && state_q != IDLE) begin
         s_d = bit_end ? '0 : s_q + S_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (tx_start) begin
               shreg_d = d_in;
               s_d     = '0;
               n_d     = '0;
               sb_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
               par_d   = (^d_in) ^ (PARITY_ODD != 0);
`endif
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               n_d     = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (n_q == N_MAX) begin
                  sb_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  n_d = n_q + N_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               sb_d    = 1'b0;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (STOP_BITS == 1 || sb_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  sb_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

endmodule
